// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with 2-bit direction counters: fetch-side lookup, execute-side
// resolution, redirect generation, table training and branch/mispredict statistics.
module branch_predictor_unit #(
  parameter int IDX_BITS = 4,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pcF,
  output logic             predTakenF,
  output logic [PC_W-1:0]  predTargetF,
  input  logic             validE,
  input  logic [2:0]       branchE,
  input  logic [1:0]       jumpE,
  input  logic [1:0]       PCSrcE,
  input  logic [PC_W-1:0]  pcE,
  input  logic [PC_W-1:0]  pcPlus4E,
  input  logic [PC_W-1:0]  pcTargetE,
  input  logic [PC_W-1:0]  jalrTargetE,
  input  logic             predTakenE,
  input  logic [PC_W-1:0]  predTargetE,
  output logic             mispredictE,
  output logic [PC_W-1:0]  redirectPCE,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredCount
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = PC_W - IDX_BITS - 2;

  logic                tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]    tbl_tag    [ENTRIES];
  logic [PC_W-1:0]     tbl_target [ENTRIES];
  logic [1:0]          tbl_ctr    [ENTRIES];

  logic [CNT_W-1:0]    branch_count;
  logic [CNT_W-1:0]    mispred_count;

  logic [IDX_BITS-1:0] idx_f;
  logic [TAG_W-1:0]    tag_f;
  logic                hit_f;
  logic [IDX_BITS-1:0] idx_e;
  logic [TAG_W-1:0]    tag_e;
  logic                hit_e;
  logic                is_cond;
  logic                is_jal;
  logic                resolve;
  logic                actual_taken;
  logic [PC_W-1:0]     actual_target;
  logic                unused_pc_bits;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign unused_pc_bits = ^{pcF[1:0], pcE[1:0]};

  // Fetch: combinational read of the registered tables (no write bypass)
  always_comb begin
    idx_f       = pcF[IDX_BITS+1:2];
    tag_f       = pcF[PC_W-1:IDX_BITS+2];
    hit_f       = tbl_valid[idx_f] && (tbl_tag[idx_f] == tag_f);
    predTakenF  = hit_f && tbl_ctr[idx_f][1];
    predTargetF = predTakenF ? tbl_target[idx_f] : '0;
  end

  // Execute: compare resolved outcome against the prediction carried down the pipe
  always_comb begin
    idx_e         = pcE[IDX_BITS+1:2];
    tag_e         = pcE[PC_W-1:IDX_BITS+2];
    hit_e         = tbl_valid[idx_e] && (tbl_tag[idx_e] == tag_e);
    is_jal        = (jumpE == 2'b01);
    is_cond       = (branchE != 3'b000) && (jumpE == 2'b00);
    resolve       = !rst && validE && ((branchE != 3'b000) || (jumpE != 2'b00));
    actual_taken  = (PCSrcE != 2'b00);
    actual_target = (PCSrcE == 2'b10) ? jalrTargetE : pcTargetE;
    mispredictE   = resolve && ((predTakenE != actual_taken) ||
                    (predTakenE && actual_taken && (predTargetE != actual_target)));
    redirectPCE   = '0;
    if (mispredictE)
      redirectPCE = actual_taken ? actual_target : pcPlus4E;
  end

  // Training and statistics take effect one edge after resolution
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= 2'b01;
      end
      branch_count  <= '0;
      mispred_count <= '0;
    end else begin
      if (resolve)
        branch_count <= cnt_sat_inc(branch_count);
      if (mispredictE)
        mispred_count <= cnt_sat_inc(mispred_count);
      if (resolve && is_cond) begin
        if (hit_e) begin
          tbl_ctr[idx_e] <= actual_taken ? ctr_inc(tbl_ctr[idx_e]) : ctr_dec(tbl_ctr[idx_e]);
          if (actual_taken)
            tbl_target[idx_e] <= pcTargetE;
        end else if (actual_taken) begin
          tbl_valid[idx_e]  <= 1'b1;
          tbl_tag[idx_e]    <= tag_e;
          tbl_target[idx_e] <= pcTargetE;
          tbl_ctr[idx_e]    <= 2'b10;
        end
      end else if (resolve && is_jal) begin
        // JAL is always taken, so it enters strongly taken
        tbl_valid[idx_e]  <= 1'b1;
        tbl_tag[idx_e]    <= tag_e;
        tbl_target[idx_e] <= pcTargetE;
        tbl_ctr[idx_e]    <= 2'b11;
      end
    end
  end

  assign branchCount  = branch_count;
  assign mispredCount = mispred_count;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit: expectations queued when stimulus is
// driven, drained and compared at the following falling edge.
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        validE;
  logic [2:0]  branchE;
  logic [1:0]  jumpE;
  logic [1:0]  PCSrcE;
  logic [31:0] pcE, pcPlus4E, pcTargetE, jalrTargetE;
  logic        predTakenE;
  logic [31:0] predTargetE;
  logic        mispredictE;
  logic [31:0] redirectPCE;
  logic [15:0] branchCount, mispredCount;

  int checks   = 0;
  int failures = 0;
  logic [15:0] m_bc = 16'h0;
  logic [15:0] m_mc = 16'h0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  branch_predictor_unit #(.IDX_BITS(4), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF), .predTargetF(predTargetF),
    .validE(validE), .branchE(branchE), .jumpE(jumpE), .PCSrcE(PCSrcE), .pcE(pcE),
    .pcPlus4E(pcPlus4E), .pcTargetE(pcTargetE), .jalrTargetE(jalrTargetE),
    .predTakenE(predTakenE), .predTargetE(predTargetE), .mispredictE(mispredictE),
    .redirectPCE(redirectPCE), .branchCount(branchCount), .mispredCount(mispredCount)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [2:0] br, input logic [1:0] jp,
                        input logic [1:0] src, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [31:0] jtgt, input logic pt, input logic [31:0] ptgt);
    validE = v; branchE = br; jumpE = jp; PCSrcE = src;
    pcE = pc; pcPlus4E = pc + 32'd4; pcTargetE = tgt; jalrTargetE = jtgt;
    predTakenE = pt; predTargetE = ptgt;
  endtask

  task automatic idle_ex();
    set_ex(1'b0, 3'b000, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic update_model(input logic mis);
    if (validE && (branchE != 3'b000 || jumpE != 2'b00)) m_bc = sat16(m_bc);
    if (mis) m_mc = sat16(m_mc);
  endtask

  // Queue expectations for the current inputs, compare at negedge, advance one clock
  task automatic step(input string name, input logic pt, input logic [31:0] ptgt,
                      input logic mis, input logic [31:0] redir);
    sbq.push_back('{{name, ".predTakenF"},   0, {31'b0, pt}});
    sbq.push_back('{{name, ".predTargetF"},  1, ptgt});
    sbq.push_back('{{name, ".mispredictE"},  2, {31'b0, mis}});
    sbq.push_back('{{name, ".redirectPCE"},  3, redir});
    sbq.push_back('{{name, ".branchCount"},  4, {16'b0, m_bc}});
    sbq.push_back('{{name, ".mispredCount"}, 5, {16'b0, m_mc}});
    @(negedge clk);
    while (sbq.size() > 0) begin
      sb_t e;
      logic [31:0] obs;
      e = sbq.pop_front();
      case (e.kind)
        0:       obs = {31'b0, predTakenF};
        1:       obs = predTargetF;
        2:       obs = {31'b0, mispredictE};
        3:       obs = redirectPCE;
        4:       obs = {16'b0, branchCount};
        default: obs = {16'b0, mispredCount};
      endcase
      check_val(e.tag, obs, e.exp);
    end
    update_model(mis);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pcF = 32'h40;
    idle_ex();
    repeat (2) @(posedge clk);
    #1;
    // Resolve coincident with reset must be dropped
    set_ex(1'b1, 3'b001, 2'b00, 2'b01, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_ex();

    step("reset", 1'b0, 32'h0, 1'b0, 32'h0);

    set_ex(1'b1, 3'b001, 2'b00, 2'b01, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0);
    step("beq_taken_miss", 1'b0, 32'h0, 1'b1, 32'h80);
    idle_ex();
    step("beq_alloc_lookup", 1'b1, 32'h80, 1'b0, 32'h0);

    set_ex(1'b1, 3'b001, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 1'b1, 32'h80);
    step("beq_nt_1", 1'b1, 32'h80, 1'b1, 32'h44);
    set_ex(1'b1, 3'b001, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0);
    step("beq_nt_2", 1'b0, 32'h0, 1'b0, 32'h0);
    idle_ex();
    step("beq_weak_nt", 1'b0, 32'h0, 1'b0, 32'h0);

    pcF = 32'h100;
    set_ex(1'b1, 3'b000, 2'b01, 2'b01, 32'h100, 32'h200, 32'h0, 1'b0, 32'h0);
    step("jal_first", 1'b0, 32'h0, 1'b1, 32'h200);
    set_ex(1'b1, 3'b000, 2'b01, 2'b01, 32'h100, 32'h200, 32'h0, 1'b1, 32'h200);
    step("jal_hit", 1'b1, 32'h200, 1'b0, 32'h0);

    // EX writes index 0 with tag of 0x40 while fetch reads 0x100: old entry seen
    set_ex(1'b1, 3'b001, 2'b00, 2'b01, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0);
    step("same_cycle_rw", 1'b1, 32'h200, 1'b1, 32'h80);
    idle_ex();
    step("after_overwrite", 1'b0, 32'h0, 1'b0, 32'h0);
    pcF = 32'h440;
    step("alias_440", 1'b0, 32'h0, 1'b0, 32'h0);
    pcF = 32'h40;
    step("lookup_40", 1'b1, 32'h80, 1'b0, 32'h0);

    set_ex(1'b0, 3'b001, 2'b00, 2'b01, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0);
    step("bubble_taken", 1'b1, 32'h80, 1'b0, 32'h0);
    set_ex(1'b0, 3'b001, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 1'b1, 32'h80);
    step("bubble_nt", 1'b1, 32'h80, 1'b0, 32'h0);
    set_ex(1'b1, 3'b000, 2'b00, 2'b01, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0);
    step("non_branch", 1'b1, 32'h80, 1'b0, 32'h0);
    idle_ex();
    step("no_update", 1'b1, 32'h80, 1'b0, 32'h0);

    set_ex(1'b1, 3'b000, 2'b10, 2'b10, 32'h40, 32'h80, 32'h300, 1'b1, 32'h80);
    step("jalr_target_miss", 1'b1, 32'h80, 1'b1, 32'h300);
    idle_ex();
    step("jalr_no_alloc", 1'b1, 32'h80, 1'b0, 32'h0);

    // Drive mispredicting JALRs until the mispredict counter reaches all-ones
    set_ex(1'b1, 3'b000, 2'b10, 2'b10, 32'h40, 32'h80, 32'h300, 1'b0, 32'h0);
    while (m_mc != 16'hFFFF) begin
      @(posedge clk);
      #1;
      update_model(1'b1);
    end
    step("sat_1", 1'b1, 32'h80, 1'b1, 32'h300);
    step("sat_2", 1'b1, 32'h80, 1'b1, 32'h300);
    idle_ex();
    step("sat_hold", 1'b1, 32'h80, 1'b0, 32'h0);
    check_val("sat_final_mc", {16'b0, mispredCount}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
Dynamic branch predictor and redirect controller for the 5-stage RISC-V pipeline. Fetch stage: a direct-mapped BTB with 2-bit saturating counters supplies predicted direction and target. Execute stage: compares the resolved outcome (PCSrcE from the branch controller) against the prediction carried down the pipe. It trains the tables, issues the redirect PC and flush request to the hazard unit, and keeps branch and mispredict statistics.

Parameters:
IDX_BITS, 4, log2 of BTB/BHT entry count (16 entries)
PC_W, 32, program counter width
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
pcF  input  PC_W  fetch-stage PC
predTakenF  output  1  prediction for pcF: taken
predTargetF  output  PC_W  predicted target for pcF (0 when predTakenF=0)
validE  input  1  execute stage holds a real (non-bubble) instruction
branchE  input  3  branch type in EX (000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE)
jumpE  input  2  jump type in EX (00 none, 01 JAL, 10 JALR)
PCSrcE  input  2  resolved next-PC select (00 pc+4, 01 pcTargetE, 10 ALU/JALR target)
pcE  input  PC_W  PC of EX instruction
pcPlus4E  input  PC_W  pcE+4
pcTargetE  input  PC_W  branch/JAL target
jalrTargetE  input  PC_W  JALR target
predTakenE  input  1  predTakenF carried to EX
predTargetE  input  PC_W  predTargetF carried to EX
mispredictE  output  1  redirect required (combinational)
redirectPCE  output  PC_W  correct next PC when mispredictE=1, else 0
branchCount  output  CNT_W  resolved conditional branches + jumps
mispredCount  output  CNT_W  mispredictions

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[PC_W-1:IDX_BITS+2]. Per entry: valid, tag, target, ctr[1:0].
- Fetch lookup, combinational from registered tables: hit = valid & tag match. predTakenF = hit & ctr[1]. predTargetF = target when predTakenF, else 0.
- actualTaken = (PCSrcE != 00). actualTarget = (PCSrcE==10) ? jalrTargetE : pcTargetE.
- Resolve only when validE=1 and (branchE!=000 or jumpE!=00); otherwise mispredictE=0, no update, no count.
- mispredictE = resolve & ((predTakenE != actualTaken) | (predTakenE & actualTaken & predTargetE != actualTarget)).
- redirectPCE = actualTaken ? actualTarget : pcPlus4E when mispredictE=1.
- Table update at clock edge after resolve (1-cycle write latency):
  - Conditional branch, entry hit: ctr saturating ++ if taken, -- if not (11 and 00 stick); target <= pcTargetE when taken.
  - Conditional branch, miss, taken: allocate valid=1, tag, target, ctr=10.
  - Conditional branch, miss, not taken: no allocation.
  - JAL: allocate or overwrite with ctr=11, target=pcTargetE.
  - JALR: never allocated. An existing entry at that index is left untouched. Counted, and mispredicted unless the carried prediction matches.
- Same-cycle fetch read and EX write to the same index: fetch sees the old contents (no bypass).
- Stats: branchCount increments per resolve. mispredCount increments per mispredictE. Both saturate at all-ones.
- Reset: all valid=0, ctr=01, target=0, tag=0, both counters=0. Outputs after reset: predTakenF=0, predTargetF=0, mispredictE=0, redirectPCE=0. A resolve coincident with rst is dropped.
- No internal stall input; the hazard unit holds validE=0 for bubbles and flushed slots.

Test Plan:
- Reset, then pcF=0x40 -> predTakenF=0, predTargetF=0, counters 0.
- BEQ at pcE=0x40, PCSrcE=01, pcTargetE=0x80, predTakenE=0 -> mispredictE=1, redirectPCE=0x80. Next cycle pcF=0x40 gives predTakenF=1, predTargetF=0x80, mispredCount=1.
- Same BEQ resolved not-taken twice with predTakenE matching the table -> ctr 10->01->00. First resolve: mispredictE=1, redirectPCE=0x44. Then predTakenF=0 at 0x40.
- JAL at 0x100 to 0x200, predTakenE=0 -> mispredictE=1, redirectPCE=0x200. Entry ctr=11. Repeat with predTakenE=1, predTargetE=0x200 -> mispredictE=0.
- Aliasing: pcE=0x40 and pcF=0x440 share index 0 with different tags -> predTakenF=0 for 0x440. Same-cycle read/write at index 0 returns the old entry.
- validE=0 with branchE=001, PCSrcE=01 -> no mispredict, no update, no count. Force mispredCount=0xFFFF, then a mispredict -> count stays 0xFFFF.
